load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
Memory-access stage between the execute datapath (ALU byte address, rs2 data) and the word-wide data memory with its registered read address. It executes RV32I loads (LB/LH/LW/LBU/LHU) and stores (SB/SH/SW) with byte-lane extraction, sign or zero extension, and read-modify-write for sub-word stores. It flags misaligned or illegal accesses and never touches memory for them.

Parameters:
addrW, 16, data-memory word-address width; byte address bits [addrW+1:2] form memAddr, higher bits ignored.

Ports:
sysCLK  input  1  system clock, all state on rising edge
sysRST  input  1  asynchronous active-high reset
reqValid  input  1  request strobe, sampled only when busy=0
reqWrite  input  1  1=store, 0=load
funct3  input  3  RV32I width/sign code
addrByte  input  32  byte address
wData  input  32  store data (rs2)
busy  output  1  high whenever state != IDLE
respValid  output  1  one-cycle completion pulse
accessFault  output  1  valid with respValid; 1 = misaligned/illegal
rData  output  32  extended load result
memAddr  output  addrW  word address to data memory (registered)
memDataW  output  32  write word to data memory (registered)
memRW  output  1  data-memory write enable (registered)
memDataR  input  32  data-memory read word, valid the cycle after memAddr is latched by memory

Behaviour:
- Reset: state=IDLE; busy, respValid, accessFault, memRW = 0; rData, memAddr, memDataW = 0. Reset mid-operation aborts immediately. memRW drops asynchronously, so no write completes. No response is issued.
- States: IDLE, LD_ADDR, LD_DATA, RMW_ADDR, RMW_DATA, ST_WR.
- Accept: in IDLE with reqValid=1 at edge E1, latch funct3, addrByte[1:0] and wData. Set memAddr <= addrByte[addrW+1:2].
- Legal funct3 for loads: 000, 001, 010, 100, 101. Legal funct3 for stores: 000, 001, 010.
- Faults: misaligned half-word (addr[0]=1) or word (addr[1:0]!=0), or an illegal funct3. At E1: respValid<=1, accessFault<=1, rData<=0, state stays IDLE. memRW is never asserted.
- Load: IDLE→LD_ADDR (E1)→LD_DATA (E2, memory latches address)→IDLE (E3). At E3: rData<=extract(memDataR), respValid<=1, accessFault<=0. respValid is high in cycle 3 after acceptance.
- Load extraction (little-endian; byte k = bits[8k+7:8k]):
  - LB/LBU: byte addr[1:0], sign- or zero-extended.
  - LH/LHU: half addr[1], sign- or zero-extended.
  - LW: whole word.
- SW: at E1, memDataW<=wData, memRW<=1, state→ST_WR. At E2, memory writes; memRW<=0, respValid<=1, state→IDLE.
- SB/SH: IDLE→RMW_ADDR (E1)→RMW_DATA (E2)→ST_WR (E3). At E3: memDataW <= memDataR with the selected lane(s) replaced by wData[7:0] or wData[15:0], and memRW<=1. At E4: write, then memRW<=0, respValid<=1, state→IDLE.
- memRW is high for exactly one cycle per legal store.
- respValid is a single-cycle pulse. During the respValid cycle the state is IDLE, so a new request may be accepted there (back-to-back).
- reqValid while busy=1 is ignored; no queueing.
- rData updates only on load responses and faults. It holds otherwise, including across stores.
- memAddr and memDataW hold their values between accesses.

Test Plan:
- Load extension: preload word0=0x8899AABB → required rData per access, respValid exactly 3 cycles after the accept edge:
  - LB 0x3 → 0xFFFFFF88
  - LBU 0x1 → 0x000000AA
  - LH 0x2 → 0xFFFF8899
  - LHU 0x0 → 0x0000AABB
  - LW 0x0 → 0x8899AABB
- SB RMW: word1=0xFFFFFFFF, SB addr 0x5, wData 0x12345677 → word1=0xFFFF77FF. memRW high one cycle; respValid 4 cycles after accept. SH addr 0x6 with wData 0x0000ABCD then gives word1=0xABCD77FF.
- SW plus back-to-back: SW addr 0x8 data 0xDEADBEEF, respValid 2 cycles after accept. LW addr 0x8 presented in the respValid cycle is accepted immediately and returns 0xDEADBEEF.
- Faults: each of the following gives respValid=1 and accessFault=1 one cycle later, rData=0, memRW never high, memory unchanged:
  - LW addr 0x2
  - SH addr 0x3
  - load funct3=011
  - store funct3=100
- Busy handling: hold reqValid=1 with varying addresses during a load → only the first request executes. busy=1 for cycles 1–2, exactly one respValid pulse.
- Reset mid-RMW: assert sysRST during RMW_DATA of SB to word2=0x01020304 → memRW=0, busy=0, state IDLE immediately, no respValid, word2 unchanged.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Request/response and data-memory signals of the load/store stage.
// slave = the load/store unit; master = execute stage plus data memory.
interface load_store_unit_if #(
  parameter int unsigned addrW = 16
);
  logic              reqValid;
  logic              reqWrite;
  logic [2:0]        funct3;
  logic [31:0]       addrByte;
  logic [31:0]       wData;
  logic              busy;
  logic              respValid;
  logic              accessFault;
  logic [31:0]       rData;
  logic [addrW-1:0]  memAddr;
  logic [31:0]       memDataW;
  logic              memRW;
  logic [31:0]       memDataR;

  modport master (
    output reqValid, reqWrite, funct3, addrByte, wData, memDataR,
    input  busy, respValid, accessFault, rData, memAddr, memDataW, memRW
  );

  modport slave (
    input  reqValid, reqWrite, funct3, addrByte, wData, memDataR,
    output busy, respValid, accessFault, rData, memAddr, memDataW, memRW
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store stage: lane extraction with sign/zero extension, read-modify-write
// for sub-word stores, and fault reporting that never touches memory.
module load_store_unit #(
  parameter int unsigned addrW = 16
) (
  input  logic               sysCLK,
  input  logic               sysRST,
  load_store_unit_if.slave   bus
);
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE, LD_ADDR, LD_DATA, RMW_ADDR, RMW_DATA, ST_WR
  } state_t;

  state_t            r_state;
  logic [2:0]        r_funct3;
  logic [1:0]        r_off;
  logic [31:0]       r_wdata;
  logic              r_resp_valid;
  logic              r_access_fault;
  logic [31:0]       r_rdata;
  logic [addrW-1:0]  r_mem_addr;
  logic [31:0]       r_mem_dataw;
  logic              r_mem_rw;

  logic              w_illegal;
  logic              w_misalign;
  logic              w_fault;
  logic [31:0]       w_sh_byte;
  logic [31:0]       w_sh_half;
  logic [31:0]       w_load_data;
  logic [31:0]       w_lane_mask;
  logic [31:0]       w_merge_data;

  // Request legality, evaluated on the live request in IDLE
  always_comb begin
    w_illegal  = 1'b0;
    w_misalign = 1'b0;
    if (bus.reqWrite)
      w_illegal = !(bus.funct3 inside {F3_B, F3_H, F3_W});
    else
      w_illegal = !(bus.funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    case (bus.funct3[1:0])
      2'b01:   w_misalign = bus.addrByte[0];
      2'b10:   w_misalign = |bus.addrByte[1:0];
      default: w_misalign = 1'b0;
    endcase
    w_fault = w_illegal | w_misalign;
  end

  // Load lane extraction from the returned word
  always_comb begin
    w_sh_byte   = bus.memDataR >> {r_off, 3'b000};
    w_sh_half   = bus.memDataR >> {r_off[1], 4'b0000};
    w_load_data = bus.memDataR;
    case (r_funct3)
      F3_B:    w_load_data = {{24{w_sh_byte[7]}}, w_sh_byte[7:0]};
      F3_H:    w_load_data = {{16{w_sh_half[15]}}, w_sh_half[15:0]};
      F3_BU:   w_load_data = {24'h0, w_sh_byte[7:0]};
      F3_HU:   w_load_data = {16'h0, w_sh_half[15:0]};
      default: w_load_data = bus.memDataR;
    endcase
  end

  // Sub-word store merge into the word read back from memory
  always_comb begin
    w_lane_mask  = (r_funct3[0] ? 32'h0000_FFFF : 32'h0000_00FF) << {r_off, 3'b000};
    w_merge_data = (bus.memDataR & ~w_lane_mask) |
                   ((r_wdata << {r_off, 3'b000}) & w_lane_mask);
  end

  always_ff @(posedge sysCLK or posedge sysRST) begin
    if (sysRST) begin
      r_state        <= IDLE;
      r_funct3       <= 3'b000;
      r_off          <= 2'b00;
      r_wdata        <= 32'h0;
      r_resp_valid   <= 1'b0;
      r_access_fault <= 1'b0;
      r_rdata        <= 32'h0;
      r_mem_addr     <= '0;
      r_mem_dataw    <= 32'h0;
      r_mem_rw       <= 1'b0;
    end else begin
      r_resp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.reqValid) begin
            r_funct3 <= bus.funct3;
            r_off    <= bus.addrByte[1:0];
            r_wdata  <= bus.wData;
            if (w_fault) begin
              r_resp_valid   <= 1'b1;
              r_access_fault <= 1'b1;
              r_rdata        <= 32'h0;
            end else begin
              r_mem_addr <= bus.addrByte[addrW+1:2];
              if (!bus.reqWrite) begin
                r_state <= LD_ADDR;
              end else if (bus.funct3 == F3_W) begin
                r_mem_dataw <= bus.wData;
                r_mem_rw    <= 1'b1;
                r_state     <= ST_WR;
              end else begin
                r_state <= RMW_ADDR;
              end
            end
          end
        end
        LD_ADDR: r_state <= LD_DATA;
        LD_DATA: begin
          r_rdata        <= w_load_data;
          r_resp_valid   <= 1'b1;
          r_access_fault <= 1'b0;
          r_state        <= IDLE;
        end
        RMW_ADDR: r_state <= RMW_DATA;
        RMW_DATA: begin
          r_mem_dataw <= w_merge_data;
          r_mem_rw    <= 1'b1;
          r_state     <= ST_WR;
        end
        ST_WR: begin
          r_mem_rw       <= 1'b0;
          r_resp_valid   <= 1'b1;
          r_access_fault <= 1'b0;
          r_state        <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy        = (r_state != IDLE);
  assign bus.respValid   = r_resp_valid;
  assign bus.accessFault = r_access_fault;
  assign bus.rData       = r_rdata;
  assign bus.memAddr     = r_mem_addr;
  assign bus.memDataW    = r_mem_dataw;
  assign bus.memRW       = r_mem_rw;
endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed test-plan cases plus random
// transactions checked against a word-array reference model.
module tb_load_store_unit;
  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned N_WORDS = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  load_store_unit_if #(.addrW(ADDR_W)) bus();
  load_store_unit #(.addrW(ADDR_W)) dut (.sysCLK(clk), .sysRST(rst), .bus(bus));

  // Synchronous data memory with a backdoor write port for preloading
  logic [31:0] mem [N_WORDS];
  logic        bd_we;
  logic [3:0]  bd_addr;
  logic [31:0] bd_data;
  always @(posedge clk) begin
    if (bd_we)           mem[bd_addr] <= bd_data;
    else if (bus.memRW)  mem[bus.memAddr[3:0]] <= bus.memDataW;
    bus.memDataR <= mem[bus.memAddr[3:0]];
  end

  logic [31:0] ref_mem [N_WORDS];
  logic [31:0] ref_rdata;
  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic ref_fault(input logic w, input logic [2:0] f3, input logic [31:0] addr);
    int unsigned size;
    logic legal;
    size  = 1 << f3[1:0];
    legal = w ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    return !legal || ((addr % size) != 0);
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [2:0] f3, input int off);
    logic [31:0] b, h;
    b = (word >> (8 * off)) & 32'hFF;
    h = (word >> (16 * (off / 2))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 32'd128)   ? (b | 32'hFFFF_FF00) : b;
      3'd1:    return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] old, input logic [2:0] f3,
                                            input int off, input logic [31:0] wd);
    logic [31:0] mask;
    if (f3 == 3'd2) return wd;
    mask = ((f3 == 3'd0) ? 32'hFF : 32'hFFFF) << (8 * off);
    return (old & ~mask) | ((wd << (8 * off)) & mask);
  endfunction

  task automatic preload(input int word, input logic [31:0] data);
    @(negedge clk);
    bd_we = 1'b1; bd_addr = 4'(word); bd_data = data;
    @(negedge clk);
    bd_we = 1'b0;
    ref_mem[word] = data;
  endtask

  task automatic run_txn(input logic w, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input string tag);
    int lat_exp, lat, rw_cnt, word, off;
    logic fault_exp;
    word = int'(addr[5:2]);
    off  = int'(addr[1:0]);
    fault_exp = ref_fault(w, f3, addr);
    if (fault_exp) begin
      lat_exp = 1; ref_rdata = 32'h0;
    end else if (!w) begin
      lat_exp = 3; ref_rdata = ref_load(ref_mem[word], f3, off);
    end else begin
      lat_exp = (f3 == 3'd2) ? 2 : 4;
      ref_mem[word] = ref_store(ref_mem[word], f3, off, wd);
    end
    @(negedge clk);
    bus.reqValid = 1'b1; bus.reqWrite = w; bus.funct3 = f3;
    bus.addrByte = addr; bus.wData = wd;
    @(posedge clk); #1;
    bus.reqValid = 1'b0;
    lat = 1; rw_cnt = 0;
    while (!bus.respValid && lat < 8) begin
      rw_cnt += int'(bus.memRW);
      @(posedge clk); #1;
      lat++;
    end
    rw_cnt += int'(bus.memRW);
    check_eq($sformatf("%s latency", tag), 32'(lat), 32'(lat_exp));
    check_eq($sformatf("%s fault", tag), 32'(bus.accessFault), 32'(fault_exp));
    check_eq($sformatf("%s rData", tag), bus.rData, ref_rdata);
    check_eq($sformatf("%s memRW cycles", tag), 32'(rw_cnt), 32'((w && !fault_exp) ? 1 : 0));
    check_eq($sformatf("%s mem word", tag), mem[word], ref_mem[word]);
  endtask

  task automatic busy_test();
    int pulses;
    ref_rdata = ref_mem[0];
    @(negedge clk);
    bus.reqValid = 1'b1; bus.reqWrite = 1'b0; bus.funct3 = 3'd2; bus.addrByte = 32'h0;
    @(posedge clk); #1;
    check_eq("busy c1", 32'(bus.busy), 32'd1);
    @(negedge clk);
    bus.addrByte = 32'($urandom_range(0, 15)) << 2;
    bus.reqWrite = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    check_eq("busy c2", 32'(bus.busy), 32'd1);
    check_eq("busy c2 resp", 32'(bus.respValid), 32'd0);
    @(negedge clk);
    bus.reqValid = 1'b0;
    @(posedge clk); #1;
    check_eq("busy c3 resp", 32'(bus.respValid), 32'd1);
    check_eq("busy c3 busy", 32'(bus.busy), 32'd0);
    check_eq("busy rData", bus.rData, ref_rdata);
    pulses = 0;
    repeat (5) begin
      @(posedge clk); #1;
      pulses += int'(bus.respValid) + int'(bus.busy) + int'(bus.memRW);
    end
    check_eq("busy extra activity", 32'(pulses), 32'd0);
  endtask

  task automatic reset_test();
    int act;
    preload(2, 32'h0102_0304);
    @(negedge clk);
    bus.reqValid = 1'b1; bus.reqWrite = 1'b1; bus.funct3 = 3'd0;
    bus.addrByte = 32'h9; bus.wData = 32'h0000_00AA;
    @(posedge clk); #1;
    bus.reqValid = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check_eq("rst memRW", 32'(bus.memRW), 32'd0);
    check_eq("rst busy", 32'(bus.busy), 32'd0);
    check_eq("rst respValid", 32'(bus.respValid), 32'd0);
    ref_rdata = 32'h0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    act = 0;
    repeat (6) begin
      @(posedge clk); #1;
      act += int'(bus.respValid) + int'(bus.memRW) + int'(bus.busy);
    end
    check_eq("rst no activity", 32'(act), 32'd0);
    check_eq("rst word2", mem[2], 32'h0102_0304);
  endtask

  initial begin
    bus.reqValid = 1'b0; bus.reqWrite = 1'b0; bus.funct3 = 3'd0;
    bus.addrByte = 32'h0; bus.wData = 32'h0;
    bd_we = 1'b0; bd_addr = 4'h0; bd_data = 32'h0;
    ref_rdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset busy", 32'(bus.busy), 32'd0);
    check_eq("reset respValid", 32'(bus.respValid), 32'd0);
    check_eq("reset accessFault", 32'(bus.accessFault), 32'd0);
    check_eq("reset memRW", 32'(bus.memRW), 32'd0);
    check_eq("reset rData", bus.rData, 32'h0);
    check_eq("reset memAddr", 32'(bus.memAddr), 32'h0);
    check_eq("reset memDataW", bus.memDataW, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < int'(N_WORDS); i++) preload(i, $urandom);
    preload(0, 32'h8899_AABB);
    preload(1, 32'hFFFF_FFFF);

    run_txn(1'b0, 3'd0, 32'h3, 32'h0, "LB 0x3");
    check_eq("LB 0x3 const", bus.rData, 32'hFFFF_FF88);
    run_txn(1'b0, 3'd4, 32'h1, 32'h0, "LBU 0x1");
    check_eq("LBU 0x1 const", bus.rData, 32'h0000_00AA);
    run_txn(1'b0, 3'd1, 32'h2, 32'h0, "LH 0x2");
    check_eq("LH 0x2 const", bus.rData, 32'hFFFF_8899);
    run_txn(1'b0, 3'd5, 32'h0, 32'h0, "LHU 0x0");
    check_eq("LHU 0x0 const", bus.rData, 32'h0000_AABB);
    run_txn(1'b0, 3'd2, 32'h0, 32'h0, "LW 0x0");
    check_eq("LW 0x0 const", bus.rData, 32'h8899_AABB);

    run_txn(1'b1, 3'd0, 32'h5, 32'h1234_5677, "SB 0x5");
    check_eq("SB word1 const", mem[1], 32'hFFFF_77FF);
    run_txn(1'b1, 3'd1, 32'h6, 32'h0000_ABCD, "SH 0x6");
    check_eq("SH word1 const", mem[1], 32'hABCD_77FF);

    run_txn(1'b1, 3'd2, 32'h8, 32'hDEAD_BEEF, "SW 0x8");
    run_txn(1'b0, 3'd2, 32'h8, 32'h0, "LW b2b 0x8");
    check_eq("LW b2b const", bus.rData, 32'hDEAD_BEEF);

    run_txn(1'b0, 3'd2, 32'h2, 32'h0, "fault LW 0x2");
    run_txn(1'b1, 3'd1, 32'h3, 32'h5555_5555, "fault SH 0x3");
    run_txn(1'b0, 3'd3, 32'h0, 32'h0, "fault ld f3=011");
    run_txn(1'b1, 3'd4, 32'h4, 32'h6666_6666, "fault st f3=100");

    busy_test();
    reset_test();

    for (int i = 0; i < 200; i++)
      run_txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
              32'($urandom_range(0, 63)), $urandom, $sformatf("rnd%0d", i));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
